// File: rtl/led_pio_blink_pkg.sv
// Shared constants for the LED PIO: Avalon register word addresses.
package led_pio_pkg;

  localparam logic [2:0] ADDR_DATA      = 3'd0;
  localparam logic [2:0] ADDR_MODE      = 3'd1;
  localparam logic [2:0] ADDR_PERIOD    = 3'd2;
  localparam logic [2:0] ADDR_STATUS    = 3'd3;
  localparam logic [2:0] ADDR_OUTSET    = 3'd4;
  localparam logic [2:0] ADDR_OUTCLEAR  = 3'd5;
  localparam logic [2:0] ADDR_OUTTOGGLE = 3'd6;

  // Avalon write strobe: selected and write_n low.
  function automatic logic wr_strobe(input logic cs, input logic wn);
    return cs && !wn;
  endfunction

endpackage

// File: rtl/led_pio_blink_if.sv
// Avalon-MM slave bus for the LED PIO (3-bit word address, 32-bit data).
interface led_pio_blink_if;
  logic [2:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;

  modport master (
    output address, chipselect, write_n, writedata,
    input  readdata
  );

  modport slave (
    input  address, chipselect, write_n, writedata,
    output readdata
  );
endinterface

// File: rtl/led_pio_blink_prescaler.sv
// Shared blink prescaler: phase toggles every PERIOD+1 cycles; restart
// clears counter and phase, taking priority over a terminal-count toggle.
module blink_prescaler #(
  parameter int unsigned PERIOD_W = 24
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [PERIOD_W-1:0] period,
  input  logic                restart,
  output logic                phase
);

  logic [PERIOD_W-1:0] cnt_q, cnt_d;
  logic                phase_q, phase_d;

  // Next counter/phase: restart wins, then terminal count, else increment.
  always_comb begin
    cnt_d   = cnt_q;
    phase_d = phase_q;
    if (restart) begin
      cnt_d   = '0;
      phase_d = 1'b0;
    end else if (cnt_q == period) begin
      cnt_d   = '0;
      phase_d = ~phase_q;
    end else begin
      cnt_d = cnt_q + PERIOD_W'(1);
    end
  end

  // Counter and phase registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      cnt_q   <= '0;
      phase_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      phase_q <= phase_d;
    end
  end

  assign phase = phase_q;

endmodule

// File: rtl/led_pio_blink.sv
// Avalon-MM LED output PIO with atomic set/clear/toggle aliases and a
// per-channel blink mode driven by one shared prescaler phase.
module led_pio_blink
  import led_pio_pkg::*;
#(
  parameter int unsigned       WIDTH          = 3,
  parameter int unsigned       PERIOD_W       = 24,
  parameter logic [WIDTH-1:0]  RESET_VALUE    = '0,
  parameter int unsigned       DEFAULT_PERIOD = 12499999
) (
  input  logic             clk,
  input  logic             reset_n,
  led_pio_blink_if.slave   avs,
  output logic [WIDTH-1:0] out_port
);

  logic [WIDTH-1:0]    data_q, data_d;
  logic [WIDTH-1:0]    mode_q, mode_d;
  logic [PERIOD_W-1:0] period_q, period_d;
  logic [WIDTH-1:0]    out_q, out_d;
  logic                phase;
  logic                we;
  logic                restart;
  logic [WIDTH-1:0]    wd_c;
  logic [31:0]         rdata_c;
  logic                unused_wd;

  assign we        = wr_strobe(avs.chipselect, avs.write_n);
  assign wd_c      = avs.writedata[WIDTH-1:0];
  assign unused_wd = ^avs.writedata;
  assign restart   = we && (avs.address == ADDR_PERIOD);

  blink_prescaler #(
    .PERIOD_W(PERIOD_W)
  ) u_prescaler (
    .clk     (clk),
    .reset_n (reset_n),
    .period  (period_q),
    .restart (restart),
    .phase   (phase)
  );

  // Register-file write decode, including the atomic DATA aliases.
  always_comb begin
    data_d   = data_q;
    mode_d   = mode_q;
    period_d = period_q;
    if (we) begin
      unique case (avs.address)
        ADDR_DATA:      data_d   = wd_c;
        ADDR_MODE:      mode_d   = wd_c;
        ADDR_PERIOD:    period_d = avs.writedata[PERIOD_W-1:0];
        ADDR_OUTSET:    data_d   = data_q | wd_c;
        ADDR_OUTCLEAR:  data_d   = data_q & ~wd_c;
        ADDR_OUTTOGGLE: data_d   = data_q ^ wd_c;
        default:        ;
      endcase
    end
  end

  // Output drive: blinking channels are gated by the shared phase.
  always_comb begin
    out_d = data_q & (~mode_q | {WIDTH{phase}});
  end

  // Register file and LED output flops.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      data_q   <= RESET_VALUE;
      mode_q   <= '0;
      period_q <= PERIOD_W'(DEFAULT_PERIOD);
      out_q    <= RESET_VALUE;
    end else begin
      data_q   <= data_d;
      mode_q   <= mode_d;
      period_q <= period_d;
      out_q    <= out_d;
    end
  end

  // Zero-wait-state read mux; unreadable addresses return zero.
  always_comb begin
    rdata_c = '0;
    unique case (avs.address)
      ADDR_DATA:   rdata_c[WIDTH-1:0]    = data_q;
      ADDR_MODE:   rdata_c[WIDTH-1:0]    = mode_q;
      ADDR_PERIOD: rdata_c[PERIOD_W-1:0] = period_q;
      ADDR_STATUS: rdata_c[0]            = phase;
      default:     ;
    endcase
  end

  assign avs.readdata = rdata_c;
  assign out_port     = out_q;

endmodule

// File: tb/tb_led_pio_blink.sv
// Self-checking bench for led_pio_blink: directed steps plus random bus
// traffic, checked against an arithmetic model of the blink phase.
module tb_led_pio_blink;
  localparam int unsigned      W   = 3;
  localparam int unsigned      PW  = 24;
  localparam logic [W-1:0]     RV  = 3'b101;
  localparam int unsigned      DEF = 12499999;

  logic         clk = 1'b0;
  logic         reset_n;
  logic [W-1:0] out_port;

  led_pio_blink_if bus ();

  always #5 clk = ~clk;

  led_pio_blink #(
    .WIDTH(W), .PERIOD_W(PW), .RESET_VALUE(RV), .DEFAULT_PERIOD(DEF)
  ) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .avs      (bus.slave),
    .out_port (out_port)
  );

  // Reference model state.
  logic [W-1:0] m_data, m_mode, m_out;
  int unsigned  m_period;
  longint       m_since;   // edges since last restart/reset
  int           tests = 0;
  int           fails = 0;

  // Phase = parity of the number of completed half-periods since restart.
  function automatic logic m_phase();
    return ((m_since / (longint'(m_period) + 1)) % 2) == 1;
  endfunction

  function automatic logic [31:0] exp_rd(input logic [2:0] a);
    case (a)
      3'd0:    return {29'b0, m_data};
      3'd1:    return {29'b0, m_mode};
      3'd2:    return {8'b0, m_period[23:0]};
      3'd3:    return {31'b0, m_phase()};
      default: return 32'b0;
    endcase
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    tests++;
    assert (got === want) else begin
      fails++;
      $error("FAIL %s got=%0h want=%0h", name, got, want);
    end
  endtask

  // One clock edge: advance model, then check out_port and readdata.
  task automatic tick();
    logic ph;
    @(posedge clk);
    ph = m_phase();
    if (!reset_n) begin
      m_data = RV; m_mode = '0; m_period = DEF; m_since = 0; m_out = RV;
    end else begin
      m_out = m_data & (~m_mode | {W{ph}});
      if (bus.chipselect && !bus.write_n) begin
        case (bus.address)
          3'd0: m_data = bus.writedata[W-1:0];
          3'd1: m_mode = bus.writedata[W-1:0];
          3'd2: m_period = {8'b0, bus.writedata[PW-1:0]};
          3'd4: m_data = m_data | bus.writedata[W-1:0];
          3'd5: m_data = m_data & ~bus.writedata[W-1:0];
          3'd6: m_data = m_data ^ bus.writedata[W-1:0];
          default: ;
        endcase
      end
      if (bus.chipselect && !bus.write_n && bus.address == 3'd2) m_since = 0;
      else m_since++;
    end
    #1;
    chk("out_port", {29'b0, out_port}, {29'b0, m_out});
    chk("readdata", bus.readdata, exp_rd(bus.address));
  endtask

  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    bus.chipselect = 1'b1; bus.write_n = 1'b0; bus.address = a; bus.writedata = d;
    tick();
    bus.write_n = 1'b1;
  endtask

  task automatic rd_check(input string name, input logic [2:0] a, input logic [31:0] want);
    bus.chipselect = 1'b1; bus.write_n = 1'b1; bus.address = a;
    #1;
    chk(name, bus.readdata, want);
  endtask

  initial begin
    bus.chipselect = 1'b0; bus.write_n = 1'b1; bus.address = '0; bus.writedata = '0;
    m_data = RV; m_mode = '0; m_period = DEF; m_since = 0; m_out = RV;

    // Reset held for 3 cycles.
    reset_n = 1'b0;
    repeat (3) tick();
    chk("rst_out", {29'b0, out_port}, 32'd5);
    reset_n = 1'b1;
    rd_check("rst_data", 3'd0, 32'd5);
    rd_check("rst_mode", 3'd1, 32'd0);
    rd_check("rst_period", 3'd2, 32'd12499999);

    // Atomic set / clear / toggle.
    wr(3'd0, 32'h1);
    wr(3'd4, 32'h6);
    rd_check("set_rd", 3'd0, 32'd7);
    tick();
    chk("set_out", {29'b0, out_port}, 32'd7);
    wr(3'd5, 32'h2);
    rd_check("clr_rd", 3'd0, 32'd5);
    tick();
    chk("clr_out", {29'b0, out_port}, 32'd5);
    wr(3'd6, 32'h3);
    rd_check("tgl_rd", 3'd0, 32'd6);
    tick();
    chk("tgl_out", {29'b0, out_port}, 32'd6);

    // Blink: PERIOD=3 on channel 1, watch STATUS and out_port.
    wr(3'd2, 32'd3);
    wr(3'd0, 32'd7);
    wr(3'd1, 32'd2);
    bus.address = 3'd3;
    repeat (20) tick();

    // Restart collision: rewrite PERIOD exactly when cnt reaches 2.
    wr(3'd2, 32'd2);
    bus.address = 3'd3;
    tick();
    tick();
    wr(3'd2, 32'd2);
    rd_check("coll_phase", 3'd3, 32'd0);
    tick();
    tick();
    chk("coll_hold", bus.readdata, 32'd0);
    tick();
    chk("coll_toggle", bus.readdata, 32'd1);

    // Reset mid-blink while phase is high.
    wr(3'd1, 32'd7);
    wr(3'd0, 32'd7);
    wr(3'd2, 32'd1);
    bus.address = 3'd3;
    for (int i = 0; i < 8 && !m_phase(); i++) tick();
    chk("pre_rst_phase", bus.readdata, 32'd1);
    reset_n = 1'b0;
    tick();
    chk("midrst_out", {29'b0, out_port}, {29'b0, RV});
    chk("midrst_phase", bus.readdata, 32'd0);
    reset_n = 1'b1;
    repeat (3) tick();

    // Ignored accesses.
    wr(3'd0, 32'd2);
    bus.chipselect = 1'b0; bus.write_n = 1'b0; bus.address = 3'd0; bus.writedata = 32'd7;
    tick();
    bus.write_n = 1'b1;
    wr(3'd3, 32'hFFFF_FFFF);
    wr(3'd7, 32'hFFFF_FFFF);
    rd_check("ign_data", 3'd0, 32'd2);
    rd_check("ign_mode", 3'd1, 32'd0);
    rd_check("ign_period", 3'd2, DEF);
    for (int a = 4; a < 8; a++) rd_check("ro_zero", 3'(a), 32'd0);

    // Random traffic against the model.
    for (int i = 0; i < 400; i++) begin
      bus.address    = 3'($urandom_range(0, 7));
      bus.chipselect = ($urandom_range(0, 3) != 0);
      bus.write_n    = 1'($urandom_range(0, 1));
      bus.writedata  = $urandom;
      if (bus.address == 3'd2) bus.writedata = $urandom_range(0, 6);
      reset_n = ($urandom_range(0, 59) != 0);
      tick();
    end
    reset_n = 1'b1;
    bus.write_n = 1'b1;
    repeat (2) tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
